alu_job_sequencer: RTL



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_job_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, sequencer state encoding
// and datapath widths.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;
  localparam int OP_W   = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } seq_state_e;

  // A held-high END from an earlier job must not complete the current one.
  function automatic logic end_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; a push into a full FIFO is
// taken only when a pop frees a slot in the same cycle.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         do_push_s;
  logic         do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/alu_job_sequencer.sv
// Issues buffered (op, X, Y, tag) jobs to the multi-cycle ALU one at a time and
// returns each result, or a timeout error, on a valid/ready interface.
module alu_job_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_x,
  input  logic [DATA_W-1:0] cmd_y,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_op,
  output logic              alu_begin,
  input  logic              alu_end,
  input  logic [OUT_W-1:0]  alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic [2:0]        res_op,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err,
  output logic              busy
);

  localparam int ENTRY_W = TAG_W + OP_W + 2 * DATA_W;
  localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e         state_r;
  logic [CNT_W-1:0]   tmo_cnt_r;
  logic [TAG_W-1:0]   tag_r;
  logic               alu_end_q_r;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic               end_rise_s;
  logic [ENTRY_W-1:0] wdata_s;
  logic [ENTRY_W-1:0] rdata_s;
  logic [DATA_W-1:0]  head_x_s;
  logic [DATA_W-1:0]  head_y_s;
  logic [2:0]         head_op_s;
  logic [TAG_W-1:0]   head_tag_s;

  assign cmd_ready  = !full_s;
  assign push_s     = cmd_valid && cmd_ready;
  assign pop_s      = (state_r == ST_IDLE) && !empty_s;
  assign wdata_s    = {cmd_tag, cmd_op, cmd_y, cmd_x};
  assign head_x_s   = rdata_s[DATA_W-1:0];
  assign head_y_s   = rdata_s[2*DATA_W-1:DATA_W];
  assign head_op_s  = rdata_s[2*DATA_W +: OP_W];
  assign head_tag_s = rdata_s[2*DATA_W+OP_W +: TAG_W];
  assign end_rise_s = end_rise(alu_end, alu_end_q_r);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Job sequencing; operands only change on a pop so the ALU sees them stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tmo_cnt_r   <= '0;
      tag_r       <= '0;
      alu_end_q_r <= 1'b0;
      alu_x       <= '0;
      alu_y       <= '0;
      alu_op      <= 3'b000;
      alu_begin   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= 3'b000;
      res_tag     <= '0;
      res_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      alu_end_q_r <= alu_end;
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            alu_x     <= head_x_s;
            alu_y     <= head_y_s;
            alu_op    <= head_op_s;
            tag_r     <= head_tag_s;
            alu_begin <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            busy      <= 1'b0;
          end
        end
        ST_ISSUE: begin
          alu_begin <= 1'b0;
          tmo_cnt_r <= '0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (end_rise_s) begin
            res_data  <= alu_out;
            res_err   <= 1'b0;
            res_op    <= alu_op;
            res_tag   <= tag_r;
            res_valid <= 1'b1;
            state_r   <= ST_HOLD;
          end else if (tmo_cnt_r == CNT_LAST) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_op    <= alu_op;
            res_tag   <= tag_r;
            res_valid <= 1'b1;
            state_r   <= ST_HOLD;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          alu_begin <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
